// File: rtl/axis_to_ps2.sv
`timescale 1ns/1ps
// AXI-Stream byte to PS/2 host-to-device frame transmitter with ACK check.
// Define PS2_CLK_FILTER_EN to glitch-filter the device clock before edge detect.
module axis_to_ps2 #(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int BIT_TIMEOUT_CYCLES   = 200000,
    parameter int FILTER_CYCLES        = 8
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_t,
    input  logic       ps2_data_i,
    output logic       ps2_data_t,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [1:0] tx_err
);

    localparam int M1   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAXC = (M1 > BIT_TIMEOUT_CYCLES) ? M1 : BIT_TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    if (FILTER_CYCLES < 1) begin : g_filter_chk
        $error("FILTER_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, TX, ACK, WAITIDLE, FINISH
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, limit_m1;
    logic [3:0]      idx, idx_n;
    logic            dbit, dbit_n;
    logic [1:0]      err_q, err_n;
    logic [7:0]      byte_q;
    logic            par_q;
    logic            up;
    logic [1:0]      clk_s, data_s;
    logic            sclk, sdata, fe, accept;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            clk_s  <= 2'b11;
            data_s <= 2'b11;
        end else begin
            clk_s  <= {clk_s[0], ps2_clk_i};
            data_s <= {data_s[0], ps2_data_i};
        end
    end

    assign sclk  = clk_s[1];
    assign sdata = data_s[1];

`ifdef PS2_CLK_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] fcnt;
    logic          armed;

    // Edge fires once the clock has stayed low long enough after a high.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            fcnt  <= '0;
            armed <= 1'b0;
        end else if (sclk) begin
            fcnt  <= '0;
            armed <= 1'b1;
        end else if (armed) begin
            if (fe) armed <= 1'b0;
            else    fcnt  <= fcnt + 1'b1;
        end
    end

    assign fe = armed & ~sclk & (fcnt == FW'(FILTER_CYCLES - 1));
`else
    logic clk_p;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) clk_p <= 1'b1;
        else          clk_p <= sclk;
    end

    assign fe = clk_p & ~sclk;
`endif

    assign accept   = s_axis_tvalid & s_axis_tready;
    assign limit_m1 = (state == TX && idx == 4'd0) ?
                      CW'(START_TIMEOUT_CYCLES - 1) : CW'(BIT_TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            dbit   <= 1'b1;
            err_q  <= 2'b00;
            byte_q <= '0;
            par_q  <= 1'b0;
            up     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            dbit  <= dbit_n;
            err_q <= err_n;
            up    <= 1'b1;
            if (accept) begin
                byte_q <= s_axis_tdata;
                par_q  <= ~^s_axis_tdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        dbit_n  = dbit;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = INHIBIT;
                    cnt_n   = '0;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) state_n = RTS;
                else                                cnt_n   = cnt + 1'b1;
            end
            RTS: begin
                state_n = TX;
                cnt_n   = '0;
                idx_n   = '0;
                dbit_n  = 1'b0;
            end
            TX: begin
                if (fe) begin
                    cnt_n = '0;
                    idx_n = idx + 4'd1;
                    if (idx < 4'd8) begin
                        dbit_n = byte_q[idx[2:0]];
                    end else if (idx == 4'd8) begin
                        dbit_n = par_q;
                    end else begin
                        dbit_n  = 1'b1;
                        state_n = ACK;
                    end
                end else if (cnt == limit_m1) begin
                    state_n = FINISH;
                    err_n   = 2'b10;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACK: begin
                if (fe) begin
                    if (!sdata) begin
                        state_n = WAITIDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = FINISH;
                        err_n   = 2'b01;
                    end
                end else if (cnt == limit_m1) begin
                    state_n = FINISH;
                    err_n   = 2'b10;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAITIDLE: begin
                if (sclk && sdata) begin
                    state_n = FINISH;
                    err_n   = 2'b00;
                end else if (fe) begin
                    cnt_n = '0;
                end else if (cnt == limit_m1) begin
                    state_n = FINISH;
                    err_n   = 2'b10;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FINISH: begin
                state_n = IDLE;
                dbit_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset releases the pins at once.
    assign ps2_clk_t     = !(state == INHIBIT || state == RTS);
    assign ps2_data_t    = (state == RTS) ? 1'b0 : (state == TX) ? dbit : 1'b1;
    assign s_axis_tready = (state == IDLE) & up;
    assign tx_busy       = (state != IDLE);
    assign tx_done       = (state == FINISH);
    assign tx_err        = err_q;

endmodule

// File: tb/tb_axis_to_ps2.sv
`timescale 1ns/1ps
// Directed bench for axis_to_ps2 with a simple open-drain PS/2 device model.
module tb_axis_to_ps2;

    localparam int INH = 20;
    localparam int STO = 500;
    localparam int BTO = 100;
    localparam int FLT = 8;
`ifdef PS2_CLK_FILTER_EN
    localparam int FE_LAT = 2 + FLT;
`else
    localparam int FE_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tready;
    logic       ps2_clk_i, ps2_clk_t;
    logic       ps2_data_i, ps2_data_t;
    logic       tx_busy, tx_done;
    logic [1:0] tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    assign ps2_clk_i  = dev_clk & ps2_clk_t;
    assign ps2_data_i = dev_data & ps2_data_t;

    axis_to_ps2 #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT_CYCLES(STO),
        .BIT_TIMEOUT_CYCLES(BTO),
        .FILTER_CYCLES(FLT)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .ps2_clk_i(ps2_clk_i),
        .ps2_clk_t(ps2_clk_t),
        .ps2_data_i(ps2_data_i),
        .ps2_data_t(ps2_data_t),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_byte(input logic [7:0] b, input bit keep, output bit ok);
        int n;
        ok = 1'b1;
        tdata = b;
        tvalid = 1'b1;
        n = 0;
        while (tready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) ok = 1'b0;
        step();
        if (!keep) tvalid = 1'b0;
        n = 0;
        while (ps2_clk_t !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) ok = 1'b0;
    endtask

    // Device: 40-cycle clock, samples host data just before each rising edge.
    task automatic dev_frame(input int nfe, input bit ack, input bit hold,
                             output logic [9:0] bits);
        bits = '0;
        steps(10);
        for (int i = 1; i <= nfe; i++) begin
            if (i == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                steps(5);
            end
            dev_clk = 1'b0;
            if (hold && i == nfe) return;
            steps(20);
            if (i <= 10) bits[i-1] = ps2_data_i;
            dev_clk = 1'b1;
            if (i == 11) begin
                steps(5);
                dev_data = 1'b1;
            end else begin
                steps(20);
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic [1:0] err,
                             output logic busy_at, output logic busy_after,
                             output logic done_after);
        seen = 1'b0;
        err = 2'b11;
        busy_at = 1'b0;
        busy_after = 1'b1;
        done_after = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                err = tx_err;
                busy_at = tx_busy;
                step();
                busy_after = tx_busy;
                done_after = tx_done;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tvalid = 1'b1;
        tdata = 8'hFF;
        steps(3);
        n_vec++;
        if ({ps2_clk_t, ps2_data_t} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_lines got %b want 11", {ps2_clk_t, ps2_data_t});
        end
        n_vec++;
        if ({tready, tx_busy, tx_done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000", {tready, tx_busy, tx_done});
        end
        n_vec++;
        if (tx_err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_err got %b want 00", tx_err);
        end
        aresetn = 1'b1;
        step();
        tvalid = 1'b0;
        n_vec++;
        if (tready !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got rdy=%b busy=%b want 1 0", tready, tx_busy);
        end
    endtask

    task automatic test_ack();
        int n;
        logic [9:0] bits;
        bit seen;
        logic [1:0] err;
        logic ba, bn, dn;
        tdata = 8'hF4;
        tvalid = 1'b1;
        step();
        tvalid = 1'b0;
        n_vec++;
        if ({tready, tx_busy, ps2_clk_t} !== 3'b010) begin
            n_err++;
            $display("FAIL accept got rdy/busy/clk_t=%b want 010",
                     {tready, tx_busy, ps2_clk_t});
        end
        n = 0;
        while (ps2_clk_t === 1'b0 && ps2_data_t === 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_vec++;
        if (n != INH) begin
            n_err++;
            $display("FAIL inhibit_len got %0d want %0d", n, INH);
        end
        n_vec++;
        if ({ps2_clk_t, ps2_data_t} !== 2'b00) begin
            n_err++;
            $display("FAIL rts got %b want 00", {ps2_clk_t, ps2_data_t});
        end
        step();
        n_vec++;
        if ({ps2_clk_t, ps2_data_t} !== 2'b10) begin
            n_err++;
            $display("FAIL clk_release got %b want 10", {ps2_clk_t, ps2_data_t});
        end
        fork
            dev_frame(11, 1'b1, 1'b0, bits);
            wait_done(2000, seen, err, ba, bn, dn);
        join
        n_vec++;
        if (bits !== 10'h2F4) begin
            n_err++;
            $display("FAIL f4_bits got %h want 2f4", bits);
        end
        n_vec++;
        if (!seen || err !== 2'b00) begin
            n_err++;
            $display("FAIL f4_done got seen=%0d err=%b want 1 00", seen, err);
        end
        n_vec++;
        if ({ba, bn, dn} !== 3'b100) begin
            n_err++;
            $display("FAIL f4_busy got %b want 100", {ba, bn, dn});
        end
    endtask

    task automatic test_nack();
        bit ok, seen;
        logic [9:0] bits;
        logic [1:0] err;
        logic ba, bn, dn;
        start_byte(8'hFF, 1'b0, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL ff_start got 0 want 1");
        end
        fork
            dev_frame(11, 1'b0, 1'b0, bits);
            wait_done(2000, seen, err, ba, bn, dn);
        join
        n_vec++;
        if (bits !== 10'h3FF) begin
            n_err++;
            $display("FAIL ff_bits got %h want 3ff", bits);
        end
        n_vec++;
        if (!seen || err !== 2'b01) begin
            n_err++;
            $display("FAIL ff_nack got seen=%0d err=%b want 1 01", seen, err);
        end
    endtask

    task automatic test_start_timeout();
        bit ok;
        int n;
        start_byte(8'h00, 1'b0, ok);
        n = 0;
        while (ps2_data_t === 1'b0 && n < 2000) begin
            step();
            n++;
        end
        n_vec++;
        if (!ok || n != STO) begin
            n_err++;
            $display("FAIL start_tmo got ok=%0d n=%0d want 1 %0d", ok, n, STO);
        end
        n_vec++;
        if ({tx_done, tx_err, ps2_clk_t} !== 4'b1101) begin
            n_err++;
            $display("FAIL start_tmo_err got %b want 1101", {tx_done, tx_err, ps2_clk_t});
        end
    endtask

    task automatic test_bit_timeout();
        bit ok, seen;
        int n;
        logic [9:0] bits;
        logic [1:0] err;
        logic ba, bn, dn;
        start_byte(8'hF3, 1'b0, ok);
        tdata = 8'h64;
        tvalid = 1'b1;
        dev_frame(4, 1'b1, 1'b1, bits);
        n_vec++;
        if (!ok || bits[2:0] !== 3'b011 || tready !== 1'b0) begin
            n_err++;
            $display("FAIL f3_partial got ok=%0d bits=%b rdy=%b want 1 011 0",
                     ok, bits[2:0], tready);
        end
        n = 0;
        while (tx_done !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        n_vec++;
        if (n != BTO + FE_LAT) begin
            n_err++;
            $display("FAIL bit_tmo got %0d want %0d", n, BTO + FE_LAT);
        end
        n_vec++;
        if ({tx_err, ps2_clk_t, ps2_data_t} !== 4'b1011) begin
            n_err++;
            $display("FAIL bit_tmo_err got %b want 1011", {tx_err, ps2_clk_t, ps2_data_t});
        end
        dev_clk = 1'b1;
        step();
        n_vec++;
        if (tready !== 1'b1) begin
            n_err++;
            $display("FAIL rdy_after_done got %b want 1", tready);
        end
        start_byte(8'h64, 1'b0, ok);
        fork
            dev_frame(11, 1'b1, 1'b0, bits);
            wait_done(2000, seen, err, ba, bn, dn);
        join
        n_vec++;
        if (!ok || bits !== 10'h264 || !seen || err !== 2'b00) begin
            n_err++;
            $display("FAIL pending_64 got ok=%0d bits=%h seen=%0d err=%b want 1 264 1 00",
                     ok, bits, seen, err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [9:0] bits;
        logic d;
        start_byte(8'h0F, 1'b0, ok);
        dev_frame(5, 1'b1, 1'b0, bits);
        n_vec++;
        if (!ok || bits[4:0] !== 5'h0F || ps2_data_t !== 1'b0) begin
            n_err++;
            $display("FAIL mid_frame got ok=%0d bits=%h dt=%b want 1 0f 0",
                     ok, bits[4:0], ps2_data_t);
        end
        d = 1'b0;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({ps2_clk_t, ps2_data_t} !== 2'b11) begin
            n_err++;
            $display("FAIL async_release got %b want 11", {ps2_clk_t, ps2_data_t});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            d = d | tx_done;
        end
        aresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            d = d | tx_done;
        end
        n_vec++;
        if (d !== 1'b0 || tready !== 1'b1 || tx_err !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset got done=%b rdy=%b err=%b want 0 1 00",
                     d, tready, tx_err);
        end
    endtask

`ifdef PS2_CLK_FILTER_EN
    task automatic test_glitch();
        bit ok;
        int n;
        logic [9:0] bits;
        start_byte(8'h04, 1'b0, ok);
        dev_frame(3, 1'b1, 1'b0, bits);
        dev_clk = 1'b0;
        steps(3);
        dev_clk = 1'b1;
        steps(15);
        n_vec++;
        if (!ok || ps2_data_t !== 1'b1) begin
            n_err++;
            $display("FAIL glitch got ok=%0d dt=%b want 1 1", ok, ps2_data_t);
        end
        n = 0;
        while (tx_done !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        n_vec++;
        if (tx_done !== 1'b1 || tx_err !== 2'b10) begin
            n_err++;
            $display("FAIL glitch_tmo got done=%b err=%b want 1 10", tx_done, tx_err);
        end
        step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ack();
        test_nack();
        test_start_timeout();
        test_bit_timeout();
        test_reset_mid();
`ifdef PS2_CLK_FILTER_EN
        test_glitch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
